// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared types and helpers for the FIFO write-side logic.
//   arb_state_e : write-arbiter FSM states
//   cnt_width() : width of a 0..max_burst-1 beat counter, never below 1 bit
// ----------------------------------------------------------------------------
package fifo_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    function automatic int cnt_width(input int max_burst);
        int w;
        w = $clog2(max_burst);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin winner search. The search starts one position
// after the last winner and wraps, so the last winner has lowest priority.
// Ports:
//   req_i   in  NumReq   request vector
//   last_i  in  IdxW     index of the previous winner
//   gnt_o   out NumReq   one-hot winner (zero when no request)
//   idx_o   out IdxW     winner index (zero when no request)
//   any_o   out 1        at least one request present
// ----------------------------------------------------------------------------
module rr_picker #(
    parameter int NumReq = 4,
    localparam int IdxW  = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   last_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              any_o
);

    logic            found;
    logic [IdxW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int off = 1; off <= NumReq; off++) begin
            cand = IdxW'((int'(last_i) + off) % NumReq);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/fifo_wr_arb.sv
// ----------------------------------------------------------------------------
// fifo_wr_arb
// Round-robin arbiter sharing one FIFO write port among NumReq valid/ready
// producers. A grant lasts up to MaxBurst beats, ends early when the granted
// producer drops valid, and is held (not released) while the FIFO is full.
// Every release costs one IDLE cycle.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ARB_IDLE  | no grant; pick next requester round-robin after last_q
// ARB_BURST | gnt_q owns the write port; beats when valid and not full
//
// Ports:
//   clk_i     in  1                  clock
//   rst_i     in  1                  async reset, active-high
//   valid_i   in  NumReq             per-producer valid
//   data_i    in  NumReq*DataWidth   producer k at [k*DataWidth +: DataWidth]
//   ready_o   out NumReq             per-producer accept
//   full_i    in  1                  FIFO full
//   wr_o      out 1                  FIFO write strobe
//   w_data_o  out DataWidth          FIFO write data (zero when not writing)
//   gnt_o     out NumReq             one-hot grant, zero when idle
//   busy_o    out 1                  high in ARB_BURST
// ----------------------------------------------------------------------------
module fifo_wr_arb
    import fifo_pkg::*;
#(
    parameter int NumReq    = 4,
    parameter int DataWidth = 8,
    parameter int MaxBurst  = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumReq-1:0]           valid_i,
    input  logic [NumReq*DataWidth-1:0] data_i,
    output logic [NumReq-1:0]           ready_o,
    input  logic                        full_i,
    output logic                        wr_o,
    output logic [DataWidth-1:0]        w_data_o,
    output logic [NumReq-1:0]           gnt_o,
    output logic                        busy_o
);

    localparam int IdxW = $clog2(NumReq);
    localparam int CntW = cnt_width(MaxBurst);
    localparam logic [CntW-1:0] LastBeat = CntW'(MaxBurst - 1);

    arb_state_e       state_q, state_d;
    logic [NumReq-1:0] gnt_q, gnt_d;
    logic [IdxW-1:0]   gnt_idx_q, gnt_idx_d;
    logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [IdxW-1:0]   last_q, last_d;

    logic [NumReq-1:0]    pick_gnt;
    logic [IdxW-1:0]      pick_idx;
    logic                 pick_any;
    logic                 valid_g;
    logic [DataWidth-1:0] sel_data;

    rr_picker #(
        .NumReq (NumReq)
    ) u_picker (
        .req_i  (valid_i),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // One-hot mux on the registered grant; zero in IDLE because gnt_q is zero.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (gnt_q[k]) begin
                sel_data = sel_data | data_i[k*DataWidth +: DataWidth];
            end
        end
    end

    assign valid_g = |(valid_i & gnt_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            beat_cnt_q <= '0;
            last_q     <= IdxW'(NumReq - 1);
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            beat_cnt_q <= beat_cnt_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        beat_cnt_d = beat_cnt_q;
        last_d     = last_q;
        ready_o    = '0;
        wr_o       = 1'b0;
        w_data_o   = '0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d    = ARB_BURST;
                    gnt_d      = pick_gnt;
                    gnt_idx_d  = pick_idx;
                    beat_cnt_d = '0;
                end
            end

            ARB_BURST: begin
                if (!valid_g) begin
                    state_d    = ARB_IDLE;
                    gnt_d      = '0;
                    beat_cnt_d = '0;
                    last_d     = gnt_idx_q;
                end else if (!full_i) begin
                    ready_o  = gnt_q;
                    wr_o     = 1'b1;
                    w_data_o = sel_data;
                    if (beat_cnt_q == LastBeat) begin
                        state_d    = ARB_IDLE;
                        gnt_d      = '0;
                        beat_cnt_d = '0;
                        last_d     = gnt_idx_q;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CntW'(1);
                    end
                end
                // full with valid: hold grant and counter untouched
            end

            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    assign gnt_o  = gnt_q;
    assign busy_o = (state_q == ARB_BURST);

endmodule

// File: tb/tb_fifo_wr_arb.sv
module tb_fifo_wr_arb;

    localparam int N = 4;
    localparam int W = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [N-1:0]  valid_i = '0;
    logic [N*W-1:0] data_i = 32'h4030_2010;
    logic          full_i = 1'b0;

    logic [N-1:0] ready0, gnt0, ready1, gnt1;
    logic         wr0, busy0, wr1, busy1;
    logic [W-1:0] wdata0, wdata1;

    always #5 clk_i = ~clk_i;

    fifo_wr_arb #(.NumReq(N), .DataWidth(W), .MaxBurst(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .data_i(data_i),
        .ready_o(ready0), .full_i(full_i), .wr_o(wr0), .w_data_o(wdata0),
        .gnt_o(gnt0), .busy_o(busy0));

    fifo_wr_arb #(.NumReq(N), .DataWidth(W), .MaxBurst(1)) dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .data_i(data_i),
        .ready_o(ready1), .full_i(full_i), .wr_o(wr1), .w_data_o(wdata1),
        .gnt_o(gnt1), .busy_o(busy1));

    logic [N-1:0] a_rdy [2];
    logic [N-1:0] a_gnt [2];
    logic         a_wr  [2];
    logic         a_busy[2];
    logic [W-1:0] a_dat [2];
    assign a_rdy[0] = ready0;  assign a_rdy[1] = ready1;
    assign a_gnt[0] = gnt0;    assign a_gnt[1] = gnt1;
    assign a_wr[0]  = wr0;     assign a_wr[1]  = wr1;
    assign a_busy[0] = busy0;  assign a_busy[1] = busy1;
    assign a_dat[0] = wdata0;  assign a_dat[1] = wdata1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: grant held as an integer producer index (-1 idle),
    // burst progress as a beat count, priority from the last winner.
    // ------------------------------------------------------------------
    int mb    [2] = '{4, 1};
    int m_gnt [2] = '{-1, -1};
    int m_last[2] = '{N-1, N-1};
    int m_cnt [2] = '{0, 0};
    int n_gnt [2] = '{-1, -1};
    int n_last[2] = '{N-1, N-1};
    int n_cnt [2] = '{0, 0};

    logic   sb_en = 1'b0;
    int     exp_seq[N];

    always @(posedge clk_i or posedge rst_i) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_i) begin
                m_gnt[i] = -1; m_last[i] = N-1; m_cnt[i] = 0;
            end else begin
                m_gnt[i] = n_gnt[i]; m_last[i] = n_last[i]; m_cnt[i] = n_cnt[i];
            end
        end
    end

    always @(negedge clk_i) begin
        logic [N-1:0] eg, er;
        logic         ew, eb;
        logic [W-1:0] ed;
        int           g, k, src;
        for (int i = 0; i < 2; i++) begin
            eg = '0; er = '0; ew = 1'b0; eb = 1'b0; ed = '0;
            n_gnt[i] = m_gnt[i]; n_last[i] = m_last[i]; n_cnt[i] = m_cnt[i];
            if (rst_i) begin
                n_gnt[i] = -1; n_last[i] = N-1; n_cnt[i] = 0;
            end else if (m_gnt[i] < 0) begin
                for (int j = 1; j <= N; j++) begin
                    k = (m_last[i] + j) % N;
                    if (n_gnt[i] < 0 && valid_i[k]) begin
                        n_gnt[i] = k;
                        n_cnt[i] = 0;
                    end
                end
            end else begin
                g = m_gnt[i];
                eg[g] = 1'b1;
                eb = 1'b1;
                if (!valid_i[g]) begin
                    n_gnt[i] = -1; n_last[i] = g;
                end else if (!full_i) begin
                    er[g] = 1'b1; ew = 1'b1; ed = data_i[g*W +: W];
                    if (m_cnt[i] + 1 == mb[i]) begin
                        n_gnt[i] = -1; n_last[i] = g; n_cnt[i] = 0;
                    end else begin
                        n_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
            chk($sformatf("d%0d_gnt", i),   a_gnt[i],  eg);
            chk($sformatf("d%0d_ready", i), a_rdy[i],  er);
            chk($sformatf("d%0d_wr", i),    a_wr[i],   ew);
            chk($sformatf("d%0d_wdata", i), a_dat[i],  ed);
            chk($sformatf("d%0d_busy", i),  a_busy[i], eb);
            chk($sformatf("d%0d_onehot0", i), $onehot0(a_gnt[i]) ? 1 : 0, 1);
            chk($sformatf("d%0d_wr_while_full", i), a_wr[i] & full_i, 0);
        end
        // Per-producer ordering of words written by the MaxBurst=4 arbiter.
        if (sb_en && wr0) begin
            src = 0;
            for (int j = N-1; j >= 0; j--) if (gnt0[j]) src = j;
            chk("sb_word", wdata0, {2'(src), 6'(exp_seq[src])});
            exp_seq[src]++;
        end
    end

    // ------------------------------------------------------------------
    // Directed cycle: called at posedge+1, drives inputs, checks one DUT
    // at the falling edge against literal expectations, returns at the
    // next posedge+1.
    // ------------------------------------------------------------------
    task automatic cyc(input logic [N-1:0] v, input logic f, input int which,
                       input logic [N-1:0] eg, input logic ew, input logic [W-1:0] ed);
        valid_i = v;
        full_i  = f;
        @(negedge clk_i);
        chk($sformatf("dir_gnt_d%0d", which),   a_gnt[which],  eg);
        chk($sformatf("dir_wr_d%0d", which),    a_wr[which],   ew);
        chk($sformatf("dir_wdata_d%0d", which), a_dat[which],  ew ? ed : 8'h00);
        chk($sformatf("dir_ready_d%0d", which), a_rdy[which],  ew ? eg : 4'h0);
        chk($sformatf("dir_busy_d%0d", which),  a_busy[which], (eg != 0) ? 1 : 0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        valid_i = '0;
        full_i  = 1'b0;
        rst_i   = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    int           prod_seq[N];
    logic [N-1:0] acc;

    initial begin
        #1;
        chk("rst_gnt", gnt0, 0);
        chk("rst_wr", wr0, 0);
        chk("rst_ready", ready0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_wdata", wdata0, 0);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 1'b0;

        // All four valid: grants 0,1,2,3,0 with 4 beats and one idle gap.
        for (int c = 0; c < 25; c++) begin
            if (c % 5 == 0)
                cyc(4'hF, 1'b0, 0, 4'h0, 1'b0, 8'h00);
            else
                cyc(4'hF, 1'b0, 0, 4'(1 << ((c / 5) % 4)), 1'b1, 8'(8'h10 * (((c / 5) % 4) + 1)));
        end
        cyc(4'h0, 1'b0, 0, 4'h0, 1'b0, 8'h00);

        // Producer 2 alone for two beats, then drops valid.
        cyc(4'b0100, 1'b0, 0, 4'b0000, 1'b0, 8'h00);
        cyc(4'b0100, 1'b0, 0, 4'b0100, 1'b1, 8'h30);
        cyc(4'b0100, 1'b0, 0, 4'b0100, 1'b1, 8'h30);
        cyc(4'b0000, 1'b0, 0, 4'b0100, 1'b0, 8'h00);
        cyc(4'b1111, 1'b0, 0, 4'b0000, 1'b0, 8'h00);
        cyc(4'b1111, 1'b0, 0, 4'b1000, 1'b1, 8'h40);  // last was 2, so 3 wins
        cyc(4'b0000, 1'b0, 0, 4'b1000, 1'b0, 8'h00);
        cyc(4'b0000, 1'b0, 0, 4'b0000, 1'b0, 8'h00);

        // Full stall of three cycles mid-burst on producer 0.
        cyc(4'b0001, 1'b0, 0, 4'b0000, 1'b0, 8'h00);
        cyc(4'b0001, 1'b0, 0, 4'b0001, 1'b1, 8'h10);
        cyc(4'b0001, 1'b0, 0, 4'b0001, 1'b1, 8'h10);
        for (int c = 0; c < 3; c++) cyc(4'b0001, 1'b1, 0, 4'b0001, 1'b0, 8'h00);
        cyc(4'b0001, 1'b0, 0, 4'b0001, 1'b1, 8'h10);
        cyc(4'b0001, 1'b0, 0, 4'b0001, 1'b1, 8'h10);
        cyc(4'b0000, 1'b0, 0, 4'b0000, 1'b0, 8'h00);

        // MaxBurst=1 instance: producers 1 and 3 alternate, one beat each.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c % 2 == 0)
                cyc(4'b1010, 1'b0, 1, 4'b0000, 1'b0, 8'h00);
            else if (c % 4 == 1)
                cyc(4'b1010, 1'b0, 1, 4'b0010, 1'b1, 8'h20);
            else
                cyc(4'b1010, 1'b0, 1, 4'b1000, 1'b1, 8'h40);
        end
        cyc(4'b0000, 1'b0, 1, 4'b0000, 1'b0, 8'h00);

        // Asynchronous reset on the second beat of a burst.
        do_reset();
        cyc(4'b0010, 1'b0, 0, 4'b0000, 1'b0, 8'h00);
        cyc(4'b0010, 1'b0, 0, 4'b0010, 1'b1, 8'h20);
        #1;
        chk("beat2_wr", wr0, 1);
        chk("beat2_gnt", gnt0, 4'b0010);
        rst_i = 1'b1;
        #1;
        chk("async_rst_gnt", gnt0, 0);
        chk("async_rst_wr", wr0, 0);
        chk("async_rst_ready", ready0, 0);
        chk("async_rst_wdata", wdata0, 0);
        chk("async_rst_busy", busy0, 0);
        valid_i = 4'b1111;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cyc(4'b1111, 1'b0, 0, 4'b0000, 1'b0, 8'h00);
        cyc(4'b1111, 1'b0, 0, 4'b0001, 1'b1, 8'h10);

        // Random valid/full traffic with stable-until-accepted producers.
        do_reset();
        for (int k = 0; k < N; k++) begin
            prod_seq[k] = 0;
            exp_seq[k]  = 0;
            data_i[k*W +: W] = {2'(k), 6'(0)};
        end
        sb_en = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk_i);
            acc = valid_i & ready0;
            @(posedge clk_i);
            #1;
            for (int k = 0; k < N; k++) begin
                if (acc[k]) begin
                    prod_seq[k]++;
                    valid_i[k] = 1'($urandom_range(0, 1));
                end else if (!valid_i[k]) begin
                    valid_i[k] = ($urandom_range(0, 2) != 0);
                end
                data_i[k*W +: W] = {2'(k), 6'(prod_seq[k])};
            end
            full_i = ($urandom_range(0, 3) == 0);
        end
        valid_i = '0;
        full_i  = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        sb_en = 1'b0;
        for (int k = 0; k < N; k++)
            chk($sformatf("sb_count_p%0d", k), exp_seq[k], prod_seq[k]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write arbiter that shares the single write port of a FIFO between `NumReq` producers. Each producer presents a valid/ready stream; the arbiter grants one producer at a time, forwards its data onto the FIFO write port, and never writes when the FIFO is full. It sits between the producer blocks and the FIFO register file plus controller (`wr_i`, `w_data`, `full_o`).

## Interface
- `NumReq`, 4, number of producers, 2..16
- `DataWidth`, 8, width of each producer's data word
- `MaxBurst`, 4, maximum beats per grant before forced re-arbitration, 1..256

- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, asynchronous, active-high
- `valid_i`  in  NumReq  per-producer data valid
- `data_i`  in  NumReq×DataWidth  packed producer data; producer k occupies `[k*DataWidth +: DataWidth]`
- `ready_o`  out  NumReq  per-producer accept; a beat transfers when `valid_i[k] & ready_o[k]`
- `full_i`  in  1  FIFO full flag
- `wr_o`  out  1  FIFO write strobe
- `w_data_o`  out  DataWidth  FIFO write data
- `gnt_o`  out  NumReq  one-hot current grant, all-zero when idle
- `busy_o`  out  1  high while in BURST

## Operation
- Two-state FSM: `ARB_IDLE`, `ARB_BURST`.
- IDLE: if any `valid_i` is set, pick the winner by round-robin. The search starts at `(last_q+1) mod NumReq` and wraps. Register the grant in `gnt_q` and set `beat_cnt_q=0`. Next state is BURST. With no requests, stay in IDLE.
- BURST, granted index g:
  - Beat occurs when `valid_i[g] & ~full_i`. Beat outputs: `ready_o[g]=1`, `wr_o=1`, `w_data_o=data_i[g]`.
  - Release to IDLE, set `last_q=g`, clear `gnt_q`, on either condition:
    - a beat with `beat_cnt_q==MaxBurst-1`;
    - `valid_i[g]==0` (no beat in that cycle).
  - Otherwise a beat increments `beat_cnt_q`.
  - `full_i=1` with `valid_i[g]=1`: hold the grant, no beat, counter unchanged. Full stalls never cause release.
- Combinational outputs from state, `valid_i` and `full_i`:
  - `ready_o` is 0 for every non-granted producer, and always 0 in IDLE.
  - `wr_o` is never 1 when `full_i=1`.
  - `w_data_o` is 0 when `wr_o=0`.
- Counter width is `$clog2(MaxBurst)` with a minimum of 1. With `MaxBurst=1`, every beat releases.
- `last_q` wraps modulo `NumReq`.

## Timing
- Reset values:
  - Registers: state=IDLE, `gnt_q=0`, `beat_cnt_q=0`, `last_q=NumReq-1`, so producer 0 has first priority.
  - Outputs: `ready_o=0`, `wr_o=0`, `w_data_o=0`, `gnt_o=0`, `busy_o=0`.
- Latency: `valid_i` rising in IDLE at cycle 0 gives `gnt_o` and `busy_o` at cycle 1. The first beat is at cycle 1 if `full_i=0`.
- Each release costs exactly one IDLE cycle. Peak throughput is `MaxBurst/(MaxBurst+1)`.
- Reset mid-burst clears the FSM immediately (asynchronous). No beat occurs in the reset cycle. Priority restarts at producer 0.
- Producers must hold `valid_i` and `data_i` stable until accepted. The arbiter does not check this.

## Structure
- Shared package `fifo_pkg`: `arb_state_e` (`ARB_IDLE`, `ARB_BURST`).
- Sub-module `rr_picker`: purely combinational.
  - Inputs: request vector and last index.
  - Outputs: one-hot winner, winner index and `any`.
  - Parameter: `NumReq`.
- Top module: FSM, counter and output muxing.

## Test plan
- After reset, all four producers valid with data 0x10/0x20/0x30/0x40, FIFO never full, `MaxBurst=4`:
  - grants go 0,1,2,3,0;
  - each grant carries 4 beats;
  - one idle cycle between grants;
  - `w_data_o` shows the matching value.
- Producer 2 alone raises valid for 2 beats, then drops it: grant is at cycle 1, beats at cycles 1-2, release at cycle 3, and `last_q=2`.
- `full_i=1` for 3 cycles in mid-burst:
  - `wr_o=0` and `ready_o=0` throughout;
  - grant is held and the counter is frozen;
  - the burst completes its remaining beats after `full_i` falls.
- `MaxBurst=1`, producers 1 and 3 continuously valid: grants alternate 1,3,1,3 with one beat each.
- Assert `rst_i` at the 2nd beat of a burst:
  - all outputs go to 0 asynchronously;
  - after release, producer 0 wins first if valid.
- Random valid/full stimulus over 10k cycles. Scoreboard checks:
  - every FIFO write equals an accepted producer word, in per-producer order;
  - `gnt_o` is always one-hot or zero;
  - no `wr_o` occurs while `full_i=1`.
